// File: rtl/dm_cache_rsp.sv
// dm_cache_rsp: direct-mapped, write-through, no-write-allocate cache responder.
// Each line holds one 64-bit doubleword. The cache serves the core's
// addr/avalid/aready request channel and its rdata/bvalid/bready response
// channel. Load misses and all stores go out on a single-outstanding req/ack
// memory port.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   addr, avalid, aready         request channel (byte address)
//   wdata, wstrb                 store data/byte enables (wstrb==0 -> load)
//   rdata, bvalid, bready        response channel
//   fence_i                      invalidate all lines
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_wstrb         memory request (held until mem_ack)
//   mem_rdata, mem_ack           memory completion (one-cycle pulse)
//   hit_cnt, miss_cnt            load hit/miss counters (DM_CACHE_PERF_EN only)
//
// Optional feature macro: DM_CACHE_PERF_EN adds the hit_cnt/miss_cnt outputs.

module dm_cache_rsp #(
   parameter  int unsigned SETS  = 64,
   localparam int unsigned IDX_W = $clog2(SETS)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        avalid,
   output logic        aready,
   output logic [63:0] rdata,
   input  logic [63:0] wdata,
   input  logic [7:0]  wstrb,
   output logic        bvalid,
   input  logic        bready,
   input  logic        fence_i,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wstrb,
   input  logic [63:0] mem_rdata,
   input  logic        mem_ack
`ifdef DM_CACHE_PERF_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);

   localparam int unsigned TAG_W = 29 - IDX_W;

   typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE, RESP} state_e;

   state_e             state_q, state_d;
   logic [31:3]        addr_q;
   logic [63:0]        wdata_q;
   logic [7:0]         wstrb_q;
   logic [63:0]        rdata_q;
   logic               fence_pend_q;
   logic [SETS-1:0]    valid_q;
   logic [TAG_W-1:0]   tag_q  [SETS];
   logic [63:0]        data_q [SETS];

   logic [IDX_W-1:0]   idx;
   logic [TAG_W-1:0]   tag;
   logic               hit;
   logic               is_store;
   logic               accept;
   logic               to_idle;
   logic               fence_clr;
   logic               unused_addr_bits;

   // Byte offset never selects anything: lines are whole doublewords.
   assign unused_addr_bits = ^addr[2:0];

   assign idx      = addr_q[3 +: IDX_W];
   assign tag      = addr_q[31 : 3 + IDX_W];
   assign hit      = valid_q[idx] && (tag_q[idx] == tag);
   assign is_store = |wstrb_q;
   assign accept   = (state_q == IDLE) && avalid && aready;
   assign to_idle  = (state_q == RESP) && bready;
   // A fence seen while busy is applied on the same edge that re-enters IDLE,
   // so the first cycle back in IDLE already sees the cleared valid bits.
   assign fence_clr = ((state_q == IDLE) && fence_i) ||
                      (to_idle && (fence_pend_q || fence_i));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (avalid && !fence_i) state_d = LOOKUP;
         LOOKUP: begin
            if (is_store) state_d = WRITE;
            else if (hit) state_d = RESP;
            else          state_d = REFILL;
         end
         REFILL: if (mem_ack) state_d = RESP;
         WRITE:  if (mem_ack) state_d = RESP;
         RESP:   if (bready)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      aready    = (state_q == IDLE) && !fence_i;
      bvalid    = (state_q == RESP);
      mem_req   = (state_q == REFILL) || (state_q == WRITE);
      mem_we    = (state_q == WRITE);
      mem_addr  = mem_req ? {addr_q, 3'b000} : '0;
      mem_wdata = mem_we  ? wdata_q : '0;
      mem_wstrb = mem_we  ? wstrb_q : '0;
   end

   assign rdata = rdata_q;

   // Request capture, response data, valid bits and pending fence
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         rdata_q      <= '0;
         valid_q      <= '0;
         fence_pend_q <= 1'b0;
      end else begin
         if (accept) begin
            addr_q  <= addr[31:3];
            wdata_q <= wdata;
            wstrb_q <= wstrb;
         end

         if (state_q == LOOKUP && !is_store && hit) rdata_q <= data_q[idx];
         else if (state_q == REFILL && mem_ack)     rdata_q <= mem_rdata;
         else if (state_q == WRITE && mem_ack)      rdata_q <= '0;

         if (fence_clr)                        valid_q      <= '0;
         else if (state_q == REFILL && mem_ack) valid_q[idx] <= 1'b1;

         if (to_idle)                          fence_pend_q <= 1'b0;
         else if (fence_i && state_q != IDLE)  fence_pend_q <= 1'b1;
      end
   end

   // Tag/data arrays need no reset: valid_q qualifies every read.
   always_ff @(posedge clk) begin
      if (state_q == REFILL && mem_ack) begin
         tag_q[idx]  <= tag;
         data_q[idx] <= mem_rdata;
      end else if (state_q == LOOKUP && is_store && hit) begin
         for (int unsigned b = 0; b < 8; b++) begin
            if (wstrb_q[b]) data_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

`ifdef DM_CACHE_PERF_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (state_q == LOOKUP && !is_store) begin
         if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
         else     miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`else
   // Counters are not built; behaviour is otherwise identical.
`endif

endmodule

// File: tb/tb_dm_cache_rsp.sv
// tb_dm_cache_rsp: directed testbench for dm_cache_rsp with a small
// memory responder inside the transaction task.

module tb_dm_cache_rsp;

   localparam int unsigned SETS = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic        avalid;
   logic        aready;
   logic [63:0] rdata;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic        fence_i;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wstrb;
   logic [63:0] mem_rdata;
   logic        mem_ack;
`ifdef DM_CACHE_PERF_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   dm_cache_rsp #(.SETS(SETS)) dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .avalid    (avalid),
      .aready    (aready),
      .rdata     (rdata),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .bvalid    (bvalid),
      .bready    (bready),
      .fence_i   (fence_i),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
`ifdef DM_CACHE_PERF_EN
      ,
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   // One request/response transaction. Inputs change and outputs are sampled
   // on the falling edge. lat counts falling edges after the accept edge at
   // which bvalid is first seen (1 = LOOKUP cycle).
   task automatic xact(input logic [31:0] a, input logic [63:0] wd, input logic [7:0] ws,
                       input int ack_dly, input logic [63:0] mrd, input int hold,
                       output logic saw_req, output logic we, output logic [31:0] maddr,
                       output logic [63:0] mwd, output logic [7:0] mws, output logic [63:0] rd,
                       output int lat, output logic stable, output logic tmo);
      int   k;
      int   n;
      logic acked;
      saw_req = 1'b0; we = 1'b0; maddr = '0; mwd = '0; mws = '0; rd = '0;
      lat = 0; stable = 1'b1; tmo = 1'b0; k = 0; n = 0; acked = 1'b0;
      @(negedge clk);
      addr = a; wdata = wd; wstrb = ws; avalid = 1'b1;
      while (!aready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!aready) begin
         avalid = 1'b0;
         tmo = 1'b1;
         return;
      end
      @(negedge clk);
      avalid = 1'b0;
      lat = 1;
      while (lat < 60) begin
         if (mem_ack) mem_ack = 1'b0;
         if (bvalid) break;
         if (mem_req) begin
            if (!saw_req) begin
               saw_req = 1'b1; we = mem_we; maddr = mem_addr; mwd = mem_wdata; mws = mem_wstrb;
            end else if (mem_addr !== maddr || mem_we !== we || mem_wdata !== mwd || mem_wstrb !== mws) begin
               stable = 1'b0;
            end
            if (!acked) begin
               if (k == ack_dly) begin
                  mem_ack = 1'b1; mem_rdata = mrd; acked = 1'b1;
               end
               k++;
            end
         end
         @(negedge clk);
         lat++;
      end
      if (!bvalid) begin
         tmo = 1'b1;
         return;
      end
      rd = rdata;
      repeat (hold) begin
         @(negedge clk);
         if (!bvalid || rdata !== rd) stable = 1'b0;
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic test_reset;
      checks++; if (aready !== 1'b1) begin failures++; $display("FAIL rst_aready got=%0b exp=1", aready); end
      checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL rst_bvalid got=%0b exp=0", bvalid); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%0b exp=0", mem_req); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%0b exp=0", mem_we); end
      checks++; if (rdata !== 64'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
      checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
      checks++; if (mem_wdata !== 64'h0) begin failures++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
      checks++; if (mem_wstrb !== 8'h0) begin failures++; $display("FAIL rst_mem_wstrb got=%h exp=0", mem_wstrb); end
`ifdef DM_CACHE_PERF_EN
      checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
`endif
   endtask

   task automatic test_cold_load;
      logic sr, we, st, tm; logic [31:0] ma; logic [63:0] mw, rd; logic [7:0] ms; int lat;
      xact(32'h8000_0000, 64'h0, 8'h00, 3, 64'h0000_0013_0010_0093, 0, sr, we, ma, mw, ms, rd, lat, st, tm);
      checks++; if (tm !== 1'b0) begin failures++; $display("FAIL cold_timeout got=%0b exp=0", tm); end
      checks++; if (sr !== 1'b1 || we !== 1'b0) begin failures++; $display("FAIL cold_req got req=%0b we=%0b exp req=1 we=0", sr, we); end
      checks++; if (ma !== 32'h8000_0000) begin failures++; $display("FAIL cold_addr got=%h exp=80000000", ma); end
      checks++; if (st !== 1'b1) begin failures++; $display("FAIL cold_stable got=%0b exp=1", st); end
      checks++; if (rd !== 64'h0000_0013_0010_0093) begin failures++; $display("FAIL cold_rdata got=%h exp=0000001300100093", rd); end
   endtask

   task automatic test_load_hit;
      logic sr, we, st, tm; logic [31:0] ma; logic [63:0] mw, rd; logic [7:0] ms; int lat;
      xact(32'h8000_0004, 64'h0, 8'h00, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, sr, we, ma, mw, ms, rd, lat, st, tm);
      checks++; if (tm !== 1'b0) begin failures++; $display("FAIL hit_timeout got=%0b exp=0", tm); end
      checks++; if (sr !== 1'b0) begin failures++; $display("FAIL hit_no_req got=%0b exp=0", sr); end
      checks++; if (lat != 2) begin failures++; $display("FAIL hit_latency got=%0d exp=2", lat); end
      checks++; if (rd !== 64'h0000_0013_0010_0093) begin failures++; $display("FAIL hit_rdata got=%h exp=0000001300100093", rd); end
`ifdef DM_CACHE_PERF_EN
      checks++; if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1) begin failures++; $display("FAIL perf_cnt got=%0d/%0d exp=1/1", hit_cnt, miss_cnt); end
`endif
   endtask

   task automatic test_store_hit;
      logic sr, we, st, tm; logic [31:0] ma; logic [63:0] mw, rd; logic [7:0] ms; int lat;
      xact(32'h8000_0000, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 2, 64'h0, 0, sr, we, ma, mw, ms, rd, lat, st, tm);
      checks++; if (tm !== 1'b0) begin failures++; $display("FAIL st_timeout got=%0b exp=0", tm); end
      checks++; if (sr !== 1'b1 || we !== 1'b1) begin failures++; $display("FAIL st_req got req=%0b we=%0b exp req=1 we=1", sr, we); end
      checks++; if (ma !== 32'h8000_0000) begin failures++; $display("FAIL st_addr got=%h exp=80000000", ma); end
      checks++; if (mw !== 64'hAAAA_AAAA_BBBB_BBBB) begin failures++; $display("FAIL st_wdata got=%h exp=aaaaaaaabbbbbbbb", mw); end
      checks++; if (ms !== 8'h0F) begin failures++; $display("FAIL st_wstrb got=%h exp=0f", ms); end
      checks++; if (rd !== 64'h0) begin failures++; $display("FAIL st_rdata got=%h exp=0", rd); end
      xact(32'h8000_0000, 64'h0, 8'h00, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, sr, we, ma, mw, ms, rd, lat, st, tm);
      checks++; if (sr !== 1'b0 || tm !== 1'b0) begin failures++; $display("FAIL st_reload_hit got req=%0b tmo=%0b exp 0/0", sr, tm); end
      checks++; if (rd !== 64'h0000_0013_BBBB_BBBB) begin failures++; $display("FAIL st_merge got=%h exp=00000013bbbbbbbb", rd); end
   endtask

   task automatic test_store_miss;
      logic sr, we, st, tm; logic [31:0] ma; logic [63:0] mw, rd; logic [7:0] ms; int lat;
      xact(32'h8000_1000, 64'h1122_3344_5566_7788, 8'hFF, 1, 64'h0, 0, sr, we, ma, mw, ms, rd, lat, st, tm);
      checks++; if (sr !== 1'b1 || we !== 1'b1 || tm !== 1'b0) begin failures++; $display("FAIL stm_req got req=%0b we=%0b tmo=%0b exp 1/1/0", sr, we, tm); end
      checks++; if (ma !== 32'h8000_1000) begin failures++; $display("FAIL stm_addr got=%h exp=80001000", ma); end
      xact(32'h8000_1000, 64'h0, 8'h00, 2, 64'hDEAD_BEEF_CAFE_F00D, 0, sr, we, ma, mw, ms, rd, lat, st, tm);
      checks++; if (sr !== 1'b1 || we !== 1'b0) begin failures++; $display("FAIL stm_noalloc got req=%0b we=%0b exp req=1 we=0", sr, we); end
      checks++; if (rd !== 64'hDEAD_BEEF_CAFE_F00D) begin failures++; $display("FAIL stm_refill got=%h exp=deadbeefcafef00d", rd); end
   endtask

   task automatic test_alias;
      logic sr, we, st, tm; logic [31:0] ma; logic [63:0] mw, rd; logic [7:0] ms; int lat;
      xact(32'h8000_0000, 64'h0, 8'h00, 1, 64'h0101_0101_0101_0101, 0, sr, we, ma, mw, ms, rd, lat, st, tm);
      checks++; if (sr !== 1'b1 || rd !== 64'h0101_0101_0101_0101) begin failures++; $display("FAIL alias_a got req=%0b rd=%h exp req=1 rd=0101010101010101", sr, rd); end
      xact(32'h8000_0000 + 8 * SETS, 64'h0, 8'h00, 1, 64'h0202_0202_0202_0202, 0, sr, we, ma, mw, ms, rd, lat, st, tm);
      checks++; if (sr !== 1'b1 || ma !== 32'h8000_0200) begin failures++; $display("FAIL alias_b got req=%0b addr=%h exp req=1 addr=80000200", sr, ma); end
      xact(32'h8000_0000, 64'h0, 8'h00, 1, 64'h0303_0303_0303_0303, 0, sr, we, ma, mw, ms, rd, lat, st, tm);
      checks++; if (sr !== 1'b1) begin failures++; $display("FAIL alias_evict got req=%0b exp=1", sr); end
      checks++; if (rd !== 64'h0303_0303_0303_0303) begin failures++; $display("FAIL alias_rdata got=%h exp=0303030303030303", rd); end
   endtask

   task automatic test_hold_and_fence;
      logic sr, we, st, tm; logic [31:0] ma; logic [63:0] mw, rd; logic [7:0] ms; int lat;
      xact(32'h8000_0000, 64'h0, 8'h00, 0, 64'h0, 5, sr, we, ma, mw, ms, rd, lat, st, tm);
      checks++; if (sr !== 1'b0 || tm !== 1'b0) begin failures++; $display("FAIL hold_hit got req=%0b tmo=%0b exp 0/0", sr, tm); end
      checks++; if (st !== 1'b1) begin failures++; $display("FAIL hold_stable got=%0b exp=1", st); end
      checks++; if (rd !== 64'h0303_0303_0303_0303) begin failures++; $display("FAIL hold_rdata got=%h exp=0303030303030303", rd); end
      @(negedge clk);
      addr = 32'h8000_0000; wstrb = 8'h00; avalid = 1'b1; fence_i = 1'b1;
      #1;
      checks++; if (aready !== 1'b0) begin failures++; $display("FAIL fence_aready got=%0b exp=0", aready); end
      @(negedge clk);
      avalid = 1'b0; fence_i = 1'b0;
      #1;
      checks++; if (aready !== 1'b1 || bvalid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL fence_idle got aready=%0b bvalid=%0b req=%0b exp 1/0/0", aready, bvalid, mem_req); end
      xact(32'h8000_0000, 64'h0, 8'h00, 1, 64'h0404_0404_0404_0404, 0, sr, we, ma, mw, ms, rd, lat, st, tm);
      checks++; if (sr !== 1'b1 || rd !== 64'h0404_0404_0404_0404) begin failures++; $display("FAIL fence_miss got req=%0b rd=%h exp req=1 rd=0404040404040404", sr, rd); end
   endtask

   task automatic test_reset_abort;
      logic sr, we, st, tm; logic [31:0] ma; logic [63:0] mw, rd; logic [7:0] ms; int lat;
      @(negedge clk);
      addr = 32'h8000_0010; wstrb = 8'h00; avalid = 1'b1;
      @(negedge clk);
      avalid = 1'b0;
      @(negedge clk);
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL abort_refill_req got=%0b exp=1", mem_req); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (mem_req !== 1'b0 || aready !== 1'b1) begin failures++; $display("FAIL abort_drop got req=%0b aready=%0b exp 0/1", mem_req, aready); end
      rst = 1'b0;
      mem_ack = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++; if (bvalid !== 1'b0 || mem_req !== 1'b0 || aready !== 1'b1) begin failures++; $display("FAIL abort_late_ack got bvalid=%0b req=%0b aready=%0b exp 0/0/1", bvalid, mem_req, aready); end
      xact(32'h8000_0010, 64'h0, 8'h00, 1, 64'h5555_6666_7777_8888, 0, sr, we, ma, mw, ms, rd, lat, st, tm);
      checks++; if (sr !== 1'b1 || rd !== 64'h5555_6666_7777_8888) begin failures++; $display("FAIL abort_reload got req=%0b rd=%h exp req=1 rd=5555666677778888", sr, rd); end
      xact(32'h8000_0000, 64'h0, 8'h00, 0, 64'h0606_0606_0606_0606, 0, sr, we, ma, mw, ms, rd, lat, st, tm);
      checks++; if (sr !== 1'b1) begin failures++; $display("FAIL abort_valid_clr got req=%0b exp=1", sr); end
   endtask

   initial begin
      rst = 1'b1; addr = '0; avalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b0;
      fence_i = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b0;
      test_cold_load();
      test_load_hit();
      test_store_hit();
      test_store_miss();
      test_alias();
      test_hold_and_fence();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
